seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_match.sv | 52 +++++
 rtl/seq_det_ctrl.sv | 122 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types for the serial pattern detector: FSM encoding and
// the configured-length range check.
package seq_det_pkg;

    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // A stored length is usable when it is 1..max_len.
    function automatic logic len_ok(
        input logic [LEN_W-1:0] len,
        input int unsigned      max_len
    );
        return (len != '0) && ({28'd0, len} <= max_len);
    endfunction

endpackage

// File: rtl/seq_match.sv
// History shift register, fill counter and masked comparator.
// Ports: i_clear, i_shift, i_x, i_pattern, i_len -> o_hit.
// o_hit is combinational and reflects the history after the
// shift that i_shift will perform on the next edge.
module seq_match
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_x,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_hit
);

    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0] w_mask;

    assign w_hist_nxt = {r_hist[PAT_W-2:0], i_x};
    assign w_fill_nxt = (r_fill < i_len) ? r_fill + LEN_W'(1) : r_fill;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(i_len));
        end
    end

    assign o_hit = i_shift && (w_fill_nxt >= i_len) &&
                   (((w_hist_nxt ^ i_pattern) & w_mask) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector control: config regs, FSM, match counter.
// Ports: cfg_* (config), start/stop, x/x_valid -> busy, match,
// match_cnt, done, cfg_err.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             cfg_err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [CNT_W-1:0] r_thresh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_match;
    logic             r_done;
    logic             r_cfg_err;

    logic             w_idle;
    logic             w_run;
    logic             w_clear;
    logic             w_shift;
    logic             w_hit;
    logic             w_len_ok;
    logic             w_start_bad;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_idle   = (r_state == S_IDLE);
    assign w_run    = (r_state == S_RUN);
    assign w_clear  = (r_state == S_ARM);
    // stop discards the sample that arrives with it
    assign w_shift  = w_run && x_valid && !stop;
    assign w_len_ok = len_ok(r_len, PAT_W);
    assign w_start_bad = w_idle && start && !cfg_we && !w_len_ok;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

    seq_match #(.PAT_W(PAT_W)) u_match (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_shift   (w_shift),
        .i_x       (x),
        .i_pattern (r_pat),
        .i_len     (r_len),
        .o_hit     (w_hit)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start && !cfg_we && w_len_ok) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_hit && (r_thresh != '0) &&
                             (w_cnt_inc == r_thresh)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_len     <= LEN_W'(PAT_W);
            r_thresh  <= '0;
            r_cnt     <= '0;
            r_match   <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_match   <= w_hit;
            r_done    <= (r_state == S_DONE);
            r_cfg_err <= w_start_bad;
            if (w_idle && cfg_we) begin
                r_pat    <= cfg_pattern;
                r_len    <= cfg_len;
                r_thresh <= cfg_thresh;
            end
            if (w_clear) begin
                r_cnt <= '0;
            end else if (w_hit) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign busy      = (r_state == S_ARM) || (r_state == S_RUN);
    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a match scoreboard.
// Expected match bits are queued when each bit is driven.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_thresh;
    logic       start;
    logic       stop;
    logic       x;
    logic       x_valid;
    logic       busy;
    logic       match;
    logic [7:0] match_cnt;
    logic       done;
    logic       cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic       exp_q[$];
    logic [7:0] m_pat;
    int         m_len;
    logic [7:0] m_hist;
    int         m_fill;
    int         m_cnt;

    seq_det_ctrl #(.PAT_W(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_thresh  (cfg_thresh),
        .start       (start),
        .stop        (stop),
        .x           (x),
        .x_valid     (x_valid),
        .busy        (busy),
        .match       (match),
        .match_cnt   (match_cnt),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                       input logic [7:0] t);
        cfg_we = 1'b1;
        cfg_pattern = p;
        cfg_len = l;
        cfg_thresh = t;
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        start = 1'b0;
        m_pat = p;
        m_len = int'(l);
    endtask

    task automatic run_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", 32'(busy), 32'd1);
        tick();
        m_hist = '0;
        m_fill = 0;
        m_cnt = 0;
        chk("arm_cnt_clr", 32'(match_cnt), 32'd0);
    endtask

    task automatic send(input logic b);
        logic [7:0] mask;
        logic       e;
        logic       got;
        m_hist = {m_hist[6:0], b};
        if (m_fill < m_len) m_fill++;
        mask = 8'((9'h1 << m_len) - 9'h1);
        e = (m_fill >= m_len) && (((m_hist ^ m_pat) & mask) == 8'h0);
        if (e) m_cnt++;
        exp_q.push_back(e);
        x = b;
        x_valid = 1'b1;
        tick();
        x_valid = 1'b0;
        got = exp_q.pop_front();
        chk("match", 32'(match), 32'(got));
        chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    endtask

    task automatic gap();
        exp_q.push_back(1'b0);
        x_valid = 1'b0;
        x = 1'b1;
        tick();
        chk("gap_match", 32'(match), 32'(exp_q.pop_front()));
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_pattern = '0;
        cfg_len = '0;
        cfg_thresh = '0;
        start = 1'b0;
        stop = 1'b0;
        x = 1'b0;
        x_valid = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 0110 overlapping, thresh 0; cfg with start held
        cfg(8'b0110, 4'd4, 8'd0);
        chk("cfg_start_ign", 32'(busy), 32'd0);
        run_start();
        send(0); send(1); send(1); send(0);
        send(1); send(1); send(0);
        chk("s1_cnt2", 32'(match_cnt), 32'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("s1_stop_idle", 32'(busy), 32'd0);
        tick();
        chk("s1_cnt_hold", 32'(match_cnt), 32'd2);

        // 111 with threshold 2
        cfg(8'b111, 4'd3, 8'd2);
        run_start();
        send(1); send(1); send(1);
        chk("s2_busy_run", 32'(busy), 32'd1);
        send(1);
        chk("s2_busy_done", 32'(busy), 32'd0);
        chk("s2_done_early", 32'(done), 32'd0);
        tick();
        chk("s2_done", 32'(done), 32'd1);
        chk("s2_busy_after", 32'(busy), 32'd0);
        chk("s2_cnt", 32'(match_cnt), 32'd2);
        tick();
        chk("s2_done_pulse", 32'(done), 32'd0);

        // bad lengths 0 and 9
        cfg(8'h0, 4'd0, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0_err", 32'(cfg_err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        tick();
        chk("len0_err_pulse", 32'(cfg_err), 32'd0);
        chk("len0_busy2", 32'(busy), 32'd0);
        cfg(8'h0, 4'd9, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len9_err", 32'(cfg_err), 32'd1);
        chk("len9_busy", 32'(busy), 32'd0);
        tick();
        chk("len9_err_pulse", 32'(cfg_err), 32'd0);

        // stop with the completing bit
        cfg(8'b0110, 4'd4, 8'd0);
        run_start();
        send(0); send(1); send(1); send(0);
        send(1); send(1);
        x = 1'b0;
        x_valid = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        x_valid = 1'b0;
        chk("stop_no_match", 32'(match), 32'd0);
        chk("stop_idle", 32'(busy), 32'd0);
        chk("stop_cnt", 32'(match_cnt), 32'd1);
        tick();
        chk("stop_no_done", 32'(done), 32'd0);

        // gaps inside the pattern
        run_start();
        send(0); gap(); send(1); send(1); gap(); gap();
        send(0); send(1); gap(); send(1); send(0);
        chk("gap_cnt2", 32'(match_cnt), 32'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // async reset mid-run, then a clean run
        run_start();
        send(0); send(1); send(1); send(0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_match", 32'(match), 32'd0);
        chk("arst_cnt", 32'(match_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_idle", 32'(busy), 32'd0);
        chk("arst_no_done", 32'(done), 32'd0);
        cfg(8'b0110, 4'd4, 8'd1);
        run_start();
        send(0); send(1); send(1); send(0);
        tick();
        chk("arst_clean_done", 32'(done), 32'd1);
        chk("arst_clean_cnt", 32'(match_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
